sarray_ld_stream: RTL
=====================

// Module: sarray_ld_stream
// PURPOSE
//  Upstream feeder of the scratchpad read channel. Accepts one load command
//  (base address, beat count, address stride) and issues one read request per
//  beat on the spad sarray_ar channel. Buffers the returned sarray_r beats in
//  a credit-protected FIFO and streams them in order to the systolic array
//  operand port over a valid/ready handshake.
// PARAMETERS
//  ADDR_W    `ADDR_WIDTH         address width of spad requests
//  DATA_W    `SARRAY_LOAD_WIDTH  width of one returned beat
//  CNT_W     16                  width of the beat count and stride fields
//  FIFO_DEP  4                   response FIFO depth (power of two, >=2)
// PORTS
//  clk           in   1         clock
//  rst_n         in   1         asynchronous active-low reset
//  cmd_valid_i   in   1         load command valid
//  cmd_ready_o   out  1         command accepted (only when IDLE)
//  cmd_base_i    in   ADDR_W    first beat address
//  cmd_len_i     in   CNT_W     beat count; 0 = no-op
//  cmd_stride_i  in   CNT_W     address increment per beat
//  ar_valid_o    out  1         spad read request valid
//  ar_ready_i    in   1         spad read request ready
//  ar_addr_o     out  ADDR_W    spad read address
//  r_valid_i     in   1         spad read data valid (cannot be stalled)
//  r_ready_o     out  1         tied to 1
//  r_data_i      in   DATA_W    spad read data
//  out_valid_o   out  1         beat to systolic array valid
//  out_ready_i   in   1         systolic array accepts beat
//  out_data_o    out  DATA_W    beat data, in command order
//  busy_o        out  1         command in progress (state != IDLE)
//  done_o        out  1         one-cycle pulse when the last beat is consumed
// BEHAVIOUR
//  - Reset: state=IDLE. Counters, FIFO pointers and credits are 0.
//    cmd_ready_o=1. ar_valid_o, out_valid_o, busy_o and done_o are 0.
//    r_ready_o=1 and ar_addr_o=0.
//  - FSM: IDLE -> ISSUE on cmd handshake with len!=0. A command with len==0
//    pulses done_o the next cycle and stays in IDLE. ISSUE -> DRAIN when the
//    last ar handshake occurs. DRAIN -> IDLE when the last beat is consumed on
//    the out handshake; done_o pulses in the same cycle as that handshake.
//    If both transitions happen in one cycle, go straight to IDLE.
//  - Issue: ar_valid_o = (state==ISSUE) & (outstanding+fifo_cnt < FIFO_DEP).
//    ar_addr_o is a registered address: base on accept, += stride on each ar
//    handshake. Addition is modulo 2^ADDR_W and wraps silently.
//    ar_valid_o and ar_addr_o are held stable until the handshake completes.
//  - Credit: outstanding += ar handshake, -= r_valid_i; both may occur in the
//    same cycle (net 0). Every r_valid_i beat is written into the FIFO
//    unconditionally. The credit rule guarantees the FIFO never overflows.
//    Tolerate any read latency >= 1 cycle, including a stalled ar_ready_i.
//  - FIFO: first-word visible, out_data_o driven straight from the head entry.
//    A simultaneous push and pop is legal at any occupancy, including empty:
//    the data then appears the following cycle, with no bypass.
//  - r_valid_i seen in IDLE is a protocol error. Drop the beat and set a sim
//    $error assertion. Also assert fifo_cnt <= FIFO_DEP.
//  - The output handshake stalls freely. out_valid_o = (fifo_cnt != 0).
//  - Reset mid-command aborts at once and returns every output to its reset
//    value. No attempt is made to drain outstanding spad reads.
// STRUCTURE
//  - Shared package/defines: `ADDR_WIDTH, `SARRAY_LOAD_WIDTH, LD_CNT_WIDTH,
//    and the FSM state encodings LD_IDLE/LD_ISSUE/LD_DRAIN.
//  - One sub-module: gnpu_sync_fifo (DATA_W, DEPTH), providing push, pop,
//    count, full, empty and head data. It can be reused for the store path.
//  - The top level holds the FSM, address and beat counters, and the
//    outstanding-credit counter.
// TESTING
//  1. base=0x100, len=4, stride=1, ar_ready=1, spad latency 2, out_ready=1
//     -> ar addrs 0x100..0x103 on 4 consecutive cycles; 4 beats out in order;
//     done_o pulses exactly once.
//  2. len=8, out_ready=0 -> ar issue stops after 4 handshakes; FIFO full.
//     Then set out_ready=1 -> remaining 4 issue, all 8 beats out, no loss.
//  3. ar_ready toggles 1/0 each cycle, stride=4 -> ar_addr stable while
//     stalled; addresses 0,4,8,...; beat order preserved.
//  4. len=0 -> cmd accepted, no ar issued, done_o pulses 1 cycle later,
//     busy_o stays 0.
//  5. base=0xFFFF_FFFE (ADDR_W=32), len=3, stride=1 -> addrs FFFF_FFFE,
//     FFFF_FFFF, 0000_0000.
//  6. rst_n low after 2 ar handshakes of len=6 -> all outputs at reset values
//     asynchronously; a new len=2 command after release completes normally.

Source files
------------

// File: rtl/sarray_ld_stream_pkg.sv
// rtl/sarray_ld_stream_pkg.sv - shared widths and FSM encodings for the scratchpad load stream
package sarray_ld_stream_pkg;

  localparam int ADDR_WIDTH        = 32;
  localparam int SARRAY_LOAD_WIDTH = 64;
  localparam int LD_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    LD_IDLE  = 2'd0,
    LD_ISSUE = 2'd1,
    LD_DRAIN = 2'd2
  } ld_state_e;

endpackage

// File: rtl/sarray_ld_stream_if.sv
// rtl/sarray_ld_stream_if.sv - command, spad ar/r and operand stream bundle of the load feeder
interface sarray_ld_stream_if #(
  parameter int ADDR_W = sarray_ld_stream_pkg::ADDR_WIDTH,
  parameter int DATA_W = sarray_ld_stream_pkg::SARRAY_LOAD_WIDTH,
  parameter int CNT_W  = sarray_ld_stream_pkg::LD_CNT_WIDTH
) ();

  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_base_i;
  logic [CNT_W-1:0]  cmd_len_i;
  logic [CNT_W-1:0]  cmd_stride_i;
  logic              ar_valid_o;
  logic              ar_ready_i;
  logic [ADDR_W-1:0] ar_addr_o;
  logic              r_valid_i;
  logic              r_ready_o;
  logic [DATA_W-1:0] r_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              busy_o;
  logic              done_o;

  modport slave (
    input  cmd_valid_i, cmd_base_i, cmd_len_i, cmd_stride_i,
    input  ar_ready_i, r_valid_i, r_data_i, out_ready_i,
    output cmd_ready_o, ar_valid_o, ar_addr_o, r_ready_o,
    output out_valid_o, out_data_o, busy_o, done_o
  );

  modport master (
    output cmd_valid_i, cmd_base_i, cmd_len_i, cmd_stride_i,
    output ar_ready_i, r_valid_i, r_data_i, out_ready_i,
    input  cmd_ready_o, ar_valid_o, ar_addr_o, r_ready_o,
    input  out_valid_o, out_data_o, busy_o, done_o
  );

endinterface

// File: rtl/gnpu_sync_fifo.sv
// rtl/gnpu_sync_fifo.sv - first-word-visible synchronous FIFO, power-of-two depth
// Push and pop in the same cycle are legal at any occupancy; there is no write-through bypass.
module gnpu_sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/sarray_ld_stream.sv
// rtl/sarray_ld_stream.sv - turns one load command into spad reads and streams the beats to the array
module sarray_ld_stream
  import sarray_ld_stream_pkg::*;
#(
  parameter int ADDR_W   = ADDR_WIDTH,
  parameter int DATA_W   = SARRAY_LOAD_WIDTH,
  parameter int CNT_W    = LD_CNT_WIDTH,
  parameter int FIFO_DEP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sarray_ld_stream_if.slave  bus
);

  localparam int            CW    = $clog2(FIFO_DEP) + 1;
  localparam logic [CW:0]   DEP_L = (CW + 1)'(FIFO_DEP);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  stride_q, stride_d;
  logic [CNT_W-1:0]  issue_left_q, issue_left_d;
  logic [CNT_W-1:0]  beat_left_q, beat_left_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic              zero_done_q, zero_done_d;

  logic [CW-1:0]     fifo_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW:0]       credit_used;
  logic              ar_hs, r_push, out_hs, last_out;

  // A request may only go out if its beat is guaranteed a FIFO slot on return.
  assign credit_used     = {1'b0, outst_q} + {1'b0, fifo_cnt};
  assign bus.ar_valid_o  = (state_q == LD_ISSUE) && (credit_used < DEP_L);
  assign bus.ar_addr_o   = addr_q;
  assign bus.cmd_ready_o = (state_q == LD_IDLE);
  assign bus.r_ready_o   = 1'b1;
  assign bus.out_valid_o = !fifo_empty;
  assign bus.busy_o      = (state_q != LD_IDLE);

  assign ar_hs    = bus.ar_valid_o && bus.ar_ready_i;
  assign r_push   = bus.r_valid_i && (state_q != LD_IDLE);
  assign out_hs   = bus.out_valid_o && bus.out_ready_i;
  assign last_out = out_hs && (beat_left_q == CNT_W'(1));

  assign bus.done_o = zero_done_q || last_out;
  assign outst_d    = outst_q + CW'(ar_hs) - CW'(r_push);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    stride_d     = stride_q;
    issue_left_d = issue_left_q;
    beat_left_d  = beat_left_q;
    zero_done_d  = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (bus.cmd_valid_i) begin
          if (bus.cmd_len_i == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d      = LD_ISSUE;
            addr_d       = bus.cmd_base_i;
            stride_d     = bus.cmd_stride_i;
            issue_left_d = bus.cmd_len_i;
            beat_left_d  = bus.cmd_len_i;
          end
        end
      end
      LD_ISSUE: begin
        if (ar_hs) begin
          addr_d       = addr_q + ADDR_W'(stride_q);
          issue_left_d = issue_left_q - CNT_W'(1);
          if (issue_left_q == CNT_W'(1)) state_d = LD_DRAIN;
        end
      end
      default: ;
    endcase
    // The final pop wins over the ISSUE->DRAIN step when both land together.
    if (out_hs) begin
      beat_left_d = beat_left_q - CNT_W'(1);
      if (last_out) state_d = LD_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LD_IDLE;
      addr_q       <= '0;
      stride_q     <= '0;
      issue_left_q <= '0;
      beat_left_q  <= '0;
      outst_q      <= '0;
      zero_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      stride_q     <= stride_d;
      issue_left_q <= issue_left_d;
      beat_left_q  <= beat_left_d;
      outst_q      <= outst_d;
      zero_done_q  <= zero_done_d;
    end
  end

  gnpu_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEP)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (r_push),
    .data_i  (bus.r_data_i),
    .pop_i   (out_hs),
    .data_o  (bus.out_data_o),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.r_valid_i && (state_q == LD_IDLE)))
        else $error("sarray_ld_stream: read beat returned while idle, dropped");
      assert ({1'b0, fifo_cnt} <= DEP_L)
        else $error("sarray_ld_stream: fifo count above depth");
      assert (!(r_push && fifo_full && !out_hs))
        else $error("sarray_ld_stream: push into full fifo");
    end
  end

endmodule
